cla_nibble_sequencer: RTL and testbench

Multi-precision add/subtract controller that time-multiplexes one 4-bit carry-lookahead slice (`four_bit_cla`) across a wide operand. It processes one nibble per clock from LSB to MSB and chains the carry through a register. A valid/ready handshake on the input and output sides lets the block sit between an operand source and a result consumer in the lab datapath.

---
 rtl/cla_nibble_sequencer_if.sv | 35 +++
 rtl/cla_nibble_sequencer.sv | 155 +++++++++++++++
 tb/tb_cla_nibble_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_nibble_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_sequencer_if
// Brief    : Operand/result valid-ready bundle for cla_nibble_sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface cla_nibble_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sub;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;
    logic           busy;

    // master = operand source / result consumer, slave = the sequencer
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/cla_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_sequencer (with leaf four_bit_cla)
// Brief    : Multi-precision add/sub reusing one 4-bit CLA slice, LSB first,
//            carry chained through a register, valid/ready on both sides.
// Revision : 1.0  initial release
// ============================================================================

module four_bit_cla (
    input  wire logic [3:0] i_a,
    input  wire logic [3:0] i_b,
    input  wire logic       i_c0,
    output logic      [3:0] o_s,
    output logic            o_c4
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry expanded from generate/propagate terms, no ripple path
    assign w_c[0] = i_c0;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c0);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c0);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c0);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c0);

    assign o_s  = w_p ^ w_c[3:0];
    assign o_c4 = w_c[4];
endmodule

module cla_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    cla_nibble_sequencer_if.slave  bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_sub;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [IDX_W+1:0]   w_shamt;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_s;
    logic               w_c4;
    logic [W-1:0]       w_sum_nxt;

    assign w_shamt = {r_idx, 2'b00};
    assign w_a_nib = 4'(r_a >> w_shamt);
    assign w_b_nib = 4'(r_b >> w_shamt) ^ {4{r_sub}};
    assign w_last  = (r_idx == c_last_idx);

    four_bit_cla u_cla (
        .i_a  (w_a_nib),
        .i_b  (w_b_nib),
        .i_c0 (r_carry),
        .o_s  (w_s),
        .o_c4 (w_c4)
    );

    // Merge the fresh nibble into its slot, leaving the other nibbles intact
    assign w_sum_nxt = (r_sum & ~(W'(4'hF) << w_shamt)) | (W'(w_s) << w_shamt);

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_RUN);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

    assign w_accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_state_nxt = S_RUN;
            S_RUN:   if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_sub   <= bus.sub;
                        // Subtraction is A + ~B + 1: the +1 enters as carry-in
                        r_carry <= bus.sub;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_c4;
                    r_idx   <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        r_cout <= w_c4;
                        r_ovf  <= (w_a_nib[3] == w_b_nib[3]) && (w_s[3] != w_a_nib[3]);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_nibble_sequencer
// Brief    : Directed vectors at NIBBLES=4 plus randomized regression at
//            NIBBLES=1/4/8 against an integer-arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cla_nibble_sequencer;
    logic clk = 1'b0;
    logic rst_d;
    logic rst_r;
    int   vecs = 0;
    int   miscomp = 0;
    bit   rdone [3];

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- directed instance ----------------
    cla_nibble_sequencer_if #(.NIBBLES(4)) dbus ();
    cla_nibble_sequencer #(.NIBBLES(4)) u_dut (
        .clk (clk),
        .rst (rst_d),
        .bus (dbus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    vec_t tbl [8];

    // Called at #1 after a rising edge; returns at #1 after the output handshake.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                         output logic [15:0] rs, output logic rc, output logic ro);
        int n;
        dbus.a = ta; dbus.b = tb_; dbus.sub = ts;
        dbus.in_valid = 1'b1; dbus.out_ready = 1'b1;
        n = 0;
        while (!dbus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("accept ready", 64'(dbus.in_ready), 64'd1);
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        dbus.a = 16'($urandom); dbus.b = 16'($urandom); dbus.sub = 1'($urandom);
        n = 0;
        while (!dbus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("latency", 64'(n), 64'd4);
        rs = dbus.sum; rc = dbus.cout; ro = dbus.ovf;
        @(posedge clk); #1;
        check("post-handshake out_valid", 64'(dbus.out_valid), 64'd0);
        check("post-handshake in_ready", 64'(dbus.in_ready), 64'd1);
    endtask

    initial begin
        logic [15:0] rs;
        logic        rc, ro;
        int          n;
        bit          saw;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[3] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[6] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_r = 1'b1;
        rst_d = 1'b1;
        dbus.in_valid = 1'b1; dbus.a = 16'h1111; dbus.b = 16'h2222;
        dbus.sub = 1'b0; dbus.out_ready = 1'b0;

        // Reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst in_ready", 64'(dbus.in_ready), 64'd0);
            check("rst out_valid", 64'(dbus.out_valid), 64'd0);
            check("rst sum", 64'(dbus.sum), 64'd0);
            check("rst cout/ovf", 64'({dbus.cout, dbus.ovf}), 64'd0);
        end
        @(posedge clk); #1;
        rst_r = 1'b0;
        rst_d = 1'b0; dbus.in_valid = 1'b0;
        #1;
        check("release in_ready", 64'(dbus.in_ready), 64'd1);
        @(posedge clk); #1;
        check("no op after reset", 64'({dbus.busy, dbus.out_valid}), 64'd0);

        // Table-driven operations
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].sub, rs, rc, ro);
            check($sformatf("vec%0d sum", i), 64'(rs), 64'(tbl[i].s));
            check($sformatf("vec%0d cout", i), 64'(rc), 64'(tbl[i].c));
            check($sformatf("vec%0d ovf", i), 64'(ro), 64'(tbl[i].o));
        end

        // Backpressure: result held while consumer stalls
        dbus.a = 16'h1234; dbus.b = 16'h4321; dbus.sub = 1'b0;
        dbus.in_valid = 1'b1; dbus.out_ready = 1'b0;
        n = 0;
        while (!dbus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        n = 0;
        while (!dbus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("bp latency", 64'(n), 64'd4);
        for (int i = 0; i < 10; i++) begin
            dbus.in_valid = 1'b1; dbus.a = 16'hFFFF; dbus.b = 16'hFFFF; dbus.sub = 1'b1;
            check("bp sum hold", 64'(dbus.sum), 64'h5555);
            check("bp ready/valid", 64'({dbus.in_ready, dbus.out_valid}), 64'b01);
            @(posedge clk); #1;
        end
        dbus.in_valid = 1'b0; dbus.out_ready = 1'b1;
        @(posedge clk); #1;
        dbus.out_ready = 1'b0;
        check("bp release", 64'({dbus.out_valid, dbus.in_ready, dbus.busy}), 64'b010);

        // Abort mid-RUN by reset, then recover
        dbus.a = 16'h00FF; dbus.b = 16'h0001; dbus.sub = 1'b0;
        dbus.in_valid = 1'b1; dbus.out_ready = 1'b1;
        n = 0;
        while (!dbus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        check("abort busy", 64'(dbus.busy), 64'd1);
        @(posedge clk); #1;
        rst_d = 1'b1;
        @(posedge clk); #1;
        rst_d = 1'b0;
        check("abort sum cleared", 64'(dbus.sum), 64'd0);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (dbus.out_valid) saw = 1'b1;
            @(posedge clk); #1;
        end
        check("abort no out_valid", 64'(saw), 64'd0);
        do_op(16'h0F0F, 16'h00F1, 1'b0, rs, rc, ro);
        check("recover sum", 64'(rs), 64'h1000);
        check("recover cout", 64'(rc), 64'd0);

        n = 0;
        while (!(rdone[0] && rdone[1] && rdone[2]) && n < 60000) begin
            @(posedge clk); n++;
        end
        check("random regression finished", 64'(rdone[0] && rdone[1] && rdone[2]), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
        $finish;
    end

    // ---------------- randomized instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int N = (g == 0) ? 1 : (g == 1) ? 4 : 8;
        localparam int W = 4 * N;

        cla_nibble_sequencer_if #(.NIBBLES(N)) rbus ();
        cla_nibble_sequencer #(.NIBBLES(N)) u_dut (
            .clk (clk),
            .rst (rst_r),
            .bus (rbus)
        );

        initial begin
            logic [W-1:0] q_sum [$];
            logic         q_c   [$];
            logic         q_o   [$];
            int           q_due [$];
            int           ops, cyc;
            bit           prev_ov;
            longint       ua, ub, sa, sb, res, smax, smin;

            rdone[g] = 1'b0;
            rbus.in_valid = 1'b0; rbus.out_ready = 1'b0;
            rbus.a = '0; rbus.b = '0; rbus.sub = 1'b0;
            smax = (longint'(1) <<< (W - 1)) - 1;
            smin = -(longint'(1) <<< (W - 1));
            ops = 0; cyc = 0; prev_ov = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            while (ops < 1000 && cyc < 40000) begin
                if (rbus.out_valid && !prev_ov) begin
                    if (q_due.size() == 0) begin
                        check($sformatf("N%0d spurious out_valid", N), 64'd1, 64'd0);
                    end else begin
                        check($sformatf("N%0d latency", N), 64'(cyc), 64'(q_due[0]));
                    end
                end
                prev_ov = rbus.out_valid;

                rbus.out_ready = ($urandom_range(0, 3) != 0);
                rbus.in_valid  = ($urandom_range(0, 2) != 0);
                rbus.a   = W'($urandom);
                rbus.b   = W'($urandom);
                rbus.sub = 1'($urandom);

                if (rbus.in_valid && rbus.in_ready) begin
                    ua = 0; ub = 0;
                    ua = rbus.a; ub = rbus.b;
                    sa = $signed(rbus.a); sb = $signed(rbus.b);
                    res = rbus.sub ? (sa - sb) : (sa + sb);
                    q_sum.push_back(rbus.sub ? W'(ua - ub) : W'(ua + ub));
                    q_c.push_back(rbus.sub ? (ua >= ub) : (((ua + ub) >> W) != 0));
                    q_o.push_back((res > smax) || (res < smin));
                    q_due.push_back(cyc + 1 + N);
                end

                if (rbus.out_valid && rbus.out_ready) begin
                    if (q_sum.size() == 0) begin
                        check($sformatf("N%0d unexpected result", N), 64'd1, 64'd0);
                    end else begin
                        check($sformatf("N%0d result {sum,cout,ovf}", N),
                              64'({rbus.sum, rbus.cout, rbus.ovf}),
                              64'({q_sum[0], q_c[0], q_o[0]}));
                        void'(q_sum.pop_front());
                        void'(q_c.pop_front());
                        void'(q_o.pop_front());
                        void'(q_due.pop_front());
                    end
                    ops++;
                end

                @(posedge clk); #1;
                cyc++;
            end
            check($sformatf("N%0d ops completed", N), 64'(ops), 64'd1000);
            rbus.in_valid = 1'b0;
            rdone[g] = 1'b1;
        end
    end
endmodule
`default_nettype wire
